// File: rtl/d2f_pkg.sv
// Shared types and divide arithmetic for the distance-to-flash-rate alert block.
package d2f_pkg;

   typedef enum logic [1:0] {
      D2F_OFF   = 2'd0,
      D2F_SOLID = 2'd1,
      D2F_FLASH = 2'd2
   } d2f_state_e;

   function automatic int unsigned d2f_scale(input int unsigned low, input int unsigned high,
                                             input int unsigned max_d, input int unsigned min_d);
      int unsigned span;
      span = (max_d > min_d) ? (max_d - min_d) : 1;
      return (low > high) ? (low - high) / span : 0;
   endfunction

   // Divide evaluated at 2*pw bits, then clamped to the slowest allowed rate.
   function automatic logic [63:0] d2f_divide(input logic [31:0] d, input int unsigned min_d,
                                              input int unsigned high, input int unsigned low,
                                              input int unsigned scale, input int unsigned pw);
      logic [63:0] v;
      v = 64'(high) + 64'(d - min_d) * 64'(scale);
      v = v & ((64'd1 << (2 * pw)) - 64'd1);
      if (v > 64'(low)) v = 64'(low);
      return v;
   endfunction

endpackage

// File: rtl/distance2frequency_channel.sv
// One alert channel: latches a distance, classifies it and drives a flashing LED
// whose period scales with distance.
module distance2frequency_channel
   import d2f_pkg::*;
#(
   parameter int WIDTH                  = 13,
   parameter int BASE_PERIOD            = 2000,
   parameter int DUTY_CYCLE             = 1000,
   parameter int MIN_FLASH_DISTANCE     = 0,
   parameter int MAX_FLASH_DISTANCE     = 2000,
   parameter int CLOCK_DIVIDE_HIGH_FREQ = 5000,
   parameter int CLOCK_DIVIDE_LOW_FREQ  = 25000,
   parameter int PERIOD_WIDTH           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] distance,
   input  logic             distance_valid,
   output logic             pwm_led
);
   localparam int TW = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
   localparam logic [31:0] MIN_U  = 32'(MIN_FLASH_DISTANCE);
   localparam logic [31:0] MAX_U  = 32'(MAX_FLASH_DISTANCE);
   localparam logic [31:0] DUTY_U = 32'(DUTY_CYCLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(BASE_PERIOD - 1);
   localparam int unsigned SCALE = d2f_scale(CLOCK_DIVIDE_LOW_FREQ, CLOCK_DIVIDE_HIGH_FREQ,
                                             MAX_FLASH_DISTANCE, MIN_FLASH_DISTANCE);

   d2f_state_e              state_q, state_d, cls;
   logic [WIDTH-1:0]        dist_q;
   logic [PERIOD_WIDTH-1:0] div_q, div_d, div_cnt_q, div_cnt_d, new_div;
   logic [TW-1:0]           tick_q, tick_d;
   logic                    led_q, led_d;
   logic                    last_div, boundary;

   always_comb begin
      cls = D2F_FLASH;
      if (32'(dist_q) >= MAX_U)      cls = D2F_OFF;
      else if (32'(dist_q) <= MIN_U) cls = D2F_SOLID;
      new_div = PERIOD_WIDTH'(d2f_divide(32'(dist_q), MIN_FLASH_DISTANCE, CLOCK_DIVIDE_HIGH_FREQ,
                                         CLOCK_DIVIDE_LOW_FREQ, SCALE, PERIOD_WIDTH));
   end

   assign last_div = ({1'b0, div_cnt_q} + (PERIOD_WIDTH+1)'(1)) >= {1'b0, div_q};
   assign boundary = last_div && (tick_q == TICK_LAST);

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      div_cnt_d = '0;
      tick_d    = '0;
      led_d     = 1'b0;
      if (!enable) begin
         state_d = D2F_OFF;
      end else begin
         unique case (state_q)
            D2F_OFF, D2F_SOLID: begin
               state_d = cls;
               led_d   = (cls != D2F_OFF);
               if (cls == D2F_FLASH) div_d = new_div;
            end
            D2F_FLASH: begin
               if (cls == D2F_SOLID) begin
                  state_d = D2F_SOLID;
                  led_d   = 1'b1;
               end else if (boundary) begin
                  // Rate changes and OFF exits wait here so no period is ever truncated.
                  if (cls == D2F_OFF) begin
                     state_d = D2F_OFF;
                  end else begin
                     div_d = new_div;
                     led_d = 1'b1;
                  end
               end else begin
                  div_cnt_d = last_div ? '0 : div_cnt_q + PERIOD_WIDTH'(1);
                  tick_d    = last_div ? tick_q + TW'(1) : tick_q;
                  led_d     = 32'(tick_d) < DUTY_U;
               end
            end
            default: state_d = D2F_OFF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dist_q    <= WIDTH'(MAX_FLASH_DISTANCE);
         state_q   <= D2F_OFF;
         div_q     <= '0;
         div_cnt_q <= '0;
         tick_q    <= '0;
         led_q     <= 1'b0;
      end else begin
         if (distance_valid) dist_q <= distance;
         state_q   <= state_d;
         div_q     <= div_d;
         div_cnt_q <= div_cnt_d;
         tick_q    <= tick_d;
         led_q     <= led_d;
      end
   end

   assign pwm_led = led_q;

endmodule

// File: rtl/distance2frequency_multi.sv
// Multi-channel distance alert: one independent flash-rate channel per distance input.
module distance2frequency_multi
   import d2f_pkg::*;
#(
   parameter int WIDTH                  = 13,
   parameter int CHANNELS               = 2,
   parameter int BASE_PERIOD            = 2000,
   parameter int DUTY_CYCLE             = 1000,
   parameter int MIN_FLASH_DISTANCE     = 0,
   parameter int MAX_FLASH_DISTANCE     = 2000,
   parameter int CLOCK_DIVIDE_HIGH_FREQ = 5000,
   parameter int CLOCK_DIVIDE_LOW_FREQ  = 25000,
   parameter int PERIOD_WIDTH           = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [CHANNELS-1:0][WIDTH-1:0]   distance,
   input  logic [CHANNELS-1:0]              distance_valid,
   output logic [CHANNELS-1:0]              pwm_led,
   output logic [CHANNELS-1:0]              pwm_out
);
   localparam int unsigned SCALE = d2f_scale(CLOCK_DIVIDE_LOW_FREQ, CLOCK_DIVIDE_HIGH_FREQ,
                                             MAX_FLASH_DISTANCE, MIN_FLASH_DISTANCE);

   if (DUTY_CYCLE > BASE_PERIOD) begin : g_err_duty
      $error("DUTY_CYCLE exceeds BASE_PERIOD");
   end
   if (MAX_FLASH_DISTANCE <= MIN_FLASH_DISTANCE) begin : g_err_range
      $error("MAX_FLASH_DISTANCE must exceed MIN_FLASH_DISTANCE");
   end
   if (SCALE < 1) begin : g_err_scale
      $error("divide scale rounds to zero");
   end
   if (64'(CLOCK_DIVIDE_LOW_FREQ) >= (64'd1 << PERIOD_WIDTH)) begin : g_err_width
      $error("CLOCK_DIVIDE_LOW_FREQ does not fit in PERIOD_WIDTH");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      distance2frequency_channel #(
         .WIDTH                  (WIDTH),
         .BASE_PERIOD            (BASE_PERIOD),
         .DUTY_CYCLE             (DUTY_CYCLE),
         .MIN_FLASH_DISTANCE     (MIN_FLASH_DISTANCE),
         .MAX_FLASH_DISTANCE     (MAX_FLASH_DISTANCE),
         .CLOCK_DIVIDE_HIGH_FREQ (CLOCK_DIVIDE_HIGH_FREQ),
         .CLOCK_DIVIDE_LOW_FREQ  (CLOCK_DIVIDE_LOW_FREQ),
         .PERIOD_WIDTH           (PERIOD_WIDTH)
      ) u_ch (
         .clk            (clk),
         .reset          (reset),
         .enable         (enable),
         .distance       (distance[i]),
         .distance_valid (distance_valid[i]),
         .pwm_led        (pwm_led[i])
      );
   end

   assign pwm_out = ~pwm_led;

endmodule

// File: tb/tb_distance2frequency_multi.sv
// Directed bench: small flash periods so every phase length can be counted by hand.
module tb_distance2frequency_multi;
   localparam int WIDTH = 13;

   logic                  clk = 1'b0;
   logic                  reset, enable;
   logic [1:0][WIDTH-1:0] distance;
   logic [1:0]            distance_valid;
   logic [1:0]            pwm_led, pwm_out;

   int total = 0;
   int bad   = 0;

   always #10 clk = ~clk;

   distance2frequency_multi #(
      .WIDTH(WIDTH), .CHANNELS(2), .BASE_PERIOD(4), .DUTY_CYCLE(2),
      .MIN_FLASH_DISTANCE(0), .MAX_FLASH_DISTANCE(8),
      .CLOCK_DIVIDE_HIGH_FREQ(2), .CLOCK_DIVIDE_LOW_FREQ(10), .PERIOD_WIDTH(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .distance(distance),
      .distance_valid(distance_valid), .pwm_led(pwm_led), .pwm_out(pwm_out)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Counts consecutive negedge samples at 'level', starting with the current one.
   task automatic run_len(input int ch, input logic level, output int n);
      n = 0;
      while (pwm_led[ch] == level && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic pulse(input logic [1:0] v, input int d0, input int d1);
      if (v[0]) distance[0] = WIDTH'(d0);
      if (v[1]) distance[1] = WIDTH'(d1);
      distance_valid = v;
      @(negedge clk);
      distance_valid = 2'b00;
   endtask

   task automatic apply(input int ch, input int d);
      pulse(ch == 0 ? 2'b01 : 2'b10, d, d);
      @(negedge clk);
   endtask

   initial begin
      int n, a, b, c, e, ones;
      reset = 1'b1; enable = 1'b1; distance = '0; distance_valid = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_led", pwm_led, 0);
      check("rst_out", pwm_out, 3);
      reset = 1'b0;
      @(negedge clk);
      check("idle_led", pwm_led, 0);

      // Distance 4 -> divide 6: 12 high / 12 low.
      pulse(2'b01, 4, 0);
      check("flash_lat1", pwm_led[0], 0);
      @(negedge clk);
      check("flash_lat2", pwm_led[0], 1);
      run_len(0, 1'b1, n); check("d4_hi0", n, 12);
      run_len(0, 1'b0, n); check("d4_lo0", n, 12);
      check("ch1_quiet", pwm_led[1], 0);
      run_len(0, 1'b1, n); check("d4_hi1", n, 12);
      run_len(0, 1'b0, n); check("d4_lo1", n, 12);

      // Rate change mid on-phase takes effect only at the next period.
      repeat (3) @(negedge clk);
      pulse(2'b01, 2, 0);
      run_len(0, 1'b1, n); check("chg_hi_old", n, 8);
      run_len(0, 1'b0, n); check("chg_lo_old", n, 12);
      run_len(0, 1'b1, n); check("d2_hi", n, 8);
      run_len(0, 1'b0, n); check("d2_lo", n, 8);

      // Flash -> solid is immediate, even from the off-phase.
      run_len(0, 1'b1, n); check("d2_hi2", n, 8);
      pulse(2'b01, 0, 0);
      check("solid_lat1", pwm_led[0], 0);
      @(negedge clk);
      check("solid_lat2", pwm_led[0], 1);
      repeat (10) @(negedge clk);
      check("solid_hold", pwm_led[0], 1);

      // Flash -> off waits for the period boundary.
      apply(0, 4);
      check("reflash", pwm_led[0], 1);
      repeat (2) @(negedge clk);
      pulse(2'b01, 8, 0);
      run_len(0, 1'b1, n); check("off_wait_hi", n, 9);
      ones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pwm_led[0]) ones++;
      end
      check("off_after_bnd", ones, 0);

      // Solid/off boundaries.
      apply(0, 0); check("d0_solid", pwm_led[0], 1);
      apply(0, 8); check("d8_off", pwm_led[0], 0);
      apply(0, 0); check("d0_solid2", pwm_led[0], 1);
      apply(0, 9); check("d9_off", pwm_led[0], 0);
      check("ch1_quiet2", pwm_led[1], 0);

      // Enable drop and reset mid-period.
      apply(0, 4);
      repeat (3) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("en_off", pwm_led, 0);
      repeat (5) @(negedge clk);
      check("en_off_hold", pwm_led, 0);
      enable = 1'b1;
      @(negedge clk);
      check("en_restart", pwm_led[0], 1);
      run_len(0, 1'b1, n); check("en_hi", n, 12);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_led", pwm_led, 0);
      check("mid_rst_out", pwm_out, 3);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst", pwm_led, 0);

      // Simultaneous strobes: divide 4 on ch0, divide 8 on ch1.
      pulse(2'b11, 2, 6);
      @(negedge clk);
      check("dual_entry", pwm_led, 3);
      fork
         begin run_len(0, 1'b1, a); run_len(0, 1'b0, b); end
         begin run_len(1, 1'b1, c); run_len(1, 1'b0, e); end
      join
      check("dual_ch0_hi", a, 8);
      check("dual_ch0_lo", b, 8);
      check("dual_ch1_hi", c, 16);
      check("dual_ch1_lo", e, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end
endmodule
